// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, format classes, bundle field widths
// and the skid-buffer occupancy states.
package decode_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FMT_W    = 3;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [FMT_W-1:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_e;

    // Shift-immediate forms of OP-IMM / OP-IMM-32 (SLLI, SRLI, SRAI)
    function automatic logic is_shift(input logic [FUNCT3_W-1:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave is the decode stage's view, master the surrounding pipeline's.
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic [XLEN-1:0]      in_pc;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [INSTR_W-1:0]   out_instr;
    logic [XLEN-1:0]      out_imm;
    fmt_e                 out_fmt;
    logic [REG_W-1:0]     out_rd;
    logic [REG_W-1:0]     out_rs1;
    logic [REG_W-1:0]     out_rs2;
    logic [FUNCT3_W-1:0]  out_funct3;
    logic                 out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_imm, out_fmt,
               out_rd, out_rs1, out_rs2, out_funct3, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_imm, out_fmt,
               out_rd, out_rs1, out_rs2, out_funct3, out_illegal
    );

endinterface

// File: rtl/decode_stage_imm_gen_x.sv
// Combinational immediate generator and format classifier for RV32/RV64.
module imm_gen_x
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm,
    output fmt_e               fmt,
    output logic               illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]          opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [XLEN-1:0]     imm_i;
    logic [XLEN-1:0]     imm_s;
    logic [XLEN-1:0]     imm_b;
    logic [XLEN-1:0]     imm_u;
    logic [XLEN-1:0]     imm_j;
    logic [XLEN-1:0]     shamt;
    logic [XLEN-1:0]     shamt_w;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign imm_i   = XLEN'($signed(instr[31:20]));
    assign imm_s   = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({instr[31:12], 12'h000}));
    assign imm_j   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign shamt   = RV64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
    assign shamt_w = XLEN'(instr[24:20]);

    // Classify the opcode, select its immediate, force illegal encodings to zero/FMT_ILL
    always_comb begin
        fmt     = FMT_ILL;
        imm     = '0;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI, OPC_AUIPC: begin
                    fmt = FMT_U;
                    imm = imm_u;
                end
                OPC_JAL: begin
                    fmt = FMT_J;
                    imm = imm_j;
                end
                OPC_JALR, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: begin
                    fmt = FMT_I;
                    imm = imm_i;
                end
                OPC_OP_IMM: begin
                    fmt = FMT_I;
                    if (is_shift(funct3)) begin
                        illegal = !RV64 && instr[25];
                        imm     = shamt;
                    end else begin
                        imm = imm_i;
                    end
                end
                OPC_BRANCH: begin
                    fmt = FMT_B;
                    imm = imm_b;
                end
                OPC_STORE: begin
                    fmt = FMT_S;
                    imm = imm_s;
                end
                OPC_OP: begin
                    fmt = FMT_R;
                end
                OPC_OP_IMM_32: begin
                    fmt = FMT_I;
                    if (!RV64) begin
                        illegal = 1'b1;
                    end else if (is_shift(funct3)) begin
                        illegal = instr[25];
                        imm     = shamt_w;
                    end else begin
                        imm = imm_i;
                    end
                end
                OPC_OP_32: begin
                    fmt     = FMT_R;
                    illegal = !RV64;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
        if (illegal) begin
            fmt = FMT_ILL;
            imm = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer between fetch and
// register-read. in_ready is a flop, so fetch never sees a path from out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter bit          RESET_PC_ZERO = 1'b1
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    decode_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    imm;
        fmt_e               fmt;
        logic               illegal;
    } bundle_t;

    skid_state_e     state;
    bundle_t         out_q;
    bundle_t         skid_q;
    bundle_t         dec;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            in_fire;
    logic            out_fire;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    imm_gen_x #(.XLEN(XLEN)) u_imm_gen (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec      = '{pc: bus.in_pc, instr: bus.in_instr, imm: dec_imm,
                        fmt: dec_fmt, illegal: dec_illegal};
    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // Occupancy FSM: moves decoded entries into the output/skid registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            if (RESET_PC_ZERO) begin
                out_q  <= '0;
                skid_q <= '0;
            end else begin
                out_q.illegal <= 1'b0;
            end
        end else if (flush) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_q       <= dec;
                        out_valid_q <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_q <= dec;
                    end else if (in_fire) begin
                        skid_q     <= dec;
                        in_ready_q <= 1'b0;
                        state      <= ST_TWO;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_instr   = out_q.instr;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_rd      = out_q.instr[11:7];
    assign bus.out_rs1     = out_q.instr[19:15];
    assign bus.out_rs2     = out_q.instr[24:20];
    assign bus.out_funct3  = out_q.instr[14:12];

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an XLEN=32 and an XLEN=64 instance
// receive identical stimulus; each has its own expected-bundle queue.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) b32 ();
    decode_stage_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.in_pc     = in_pc[31:0];
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.in_pc     = in_pc;
    assign b64.out_ready = out_ready;

    decode_stage #(.XLEN(32), .RESET_PC_ZERO(1'b1)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b32)
    );
    decode_stage #(.XLEN(64), .RESET_PC_ZERO(1'b1)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode written directly from the RISC-V immediate layouts
    function automatic exp_t ref_dec(input int xl, input logic [31:0] ins, input logic [63:0] pc);
        exp_t   e;
        longint s;
        bit     sh;
        bit     bad;
        sh    = (ins[13:12] == 2'b01);
        s     = 0;
        bad   = 0;
        e.fmt = 3'd7;
        e.instr = ins;
        e.pc  = (xl == 32) ? {32'h0, pc[31:0]} : pc;
        if (ins[1:0] != 2'b11) bad = 1;
        else case (ins[6:0])
            7'h37, 7'h17: begin e.fmt = 3'd4; s = $signed({ins[31:12], 12'h000}); end
            7'h6F: begin e.fmt = 3'd5; s = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
            7'h67, 7'h03, 7'h0F, 7'h73: begin e.fmt = 3'd1; s = $signed(ins[31:20]); end
            7'h13: begin
                e.fmt = 3'd1;
                if (!sh) s = $signed(ins[31:20]);
                else if (xl == 64) s = ins[25:20];
                else begin s = ins[24:20]; bad = ins[25]; end
            end
            7'h63: begin e.fmt = 3'd3; s = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
            7'h23: begin e.fmt = 3'd2; s = $signed({ins[31:25], ins[11:7]}); end
            7'h33: e.fmt = 3'd0;
            7'h1B: begin
                if (xl == 32 || (sh && ins[25])) bad = 1;
                else begin
                    e.fmt = 3'd1;
                    if (sh) s = ins[24:20];
                    else s = $signed(ins[31:20]);
                end
            end
            7'h3B: if (xl == 32) bad = 1; else e.fmt = 3'd0;
            default: bad = 1;
        endcase
        if (bad) begin e.fmt = 3'd7; s = 0; end
        e.ill = bad;
        e.imm = (xl == 32) ? {32'h0, s[31:0]} : s;
        return e;
    endfunction

    task automatic score(input int xl, input logic [63:0] pc, input logic [31:0] ins,
                         input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3);
        exp_t e;
        int   n;
        n = (xl == 32) ? q32.size() : q64.size();
        check($sformatf("x%0d_sb_pending", xl), 64'(n != 0), 64'd1);
        if (n != 0) begin
            if (xl == 32) e = q32.pop_front();
            else e = q64.pop_front();
            check($sformatf("x%0d_pc", xl), pc, e.pc);
            check($sformatf("x%0d_instr", xl), 64'(ins), 64'(e.instr));
            check($sformatf("x%0d_imm", xl), imm, e.imm);
            check($sformatf("x%0d_fmt", xl), 64'(fmt), 64'(e.fmt));
            check($sformatf("x%0d_illegal", xl), 64'(ill), 64'(e.ill));
            check($sformatf("x%0d_regs", xl), 64'({rd, rs1, rs2, f3}),
                  64'({e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12]}));
        end
    endtask

    // Monitor: compare consumed bundles, enqueue accepted inputs
    always @(negedge clk) begin
        if (rst || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (b32.out_valid && out_ready)
                score(32, 64'(b32.out_pc), b32.out_instr, 64'(b32.out_imm), b32.out_fmt,
                      b32.out_illegal, b32.out_rd, b32.out_rs1, b32.out_rs2, b32.out_funct3);
            if (b64.out_valid && out_ready)
                score(64, b64.out_pc, b64.out_instr, b64.out_imm, b64.out_fmt,
                      b64.out_illegal, b64.out_rd, b64.out_rs1, b64.out_rs2, b64.out_funct3);
            if (in_valid && b32.in_ready) q32.push_back(ref_dec(32, in_instr, in_pc));
            if (in_valid && b64.in_ready) q64.push_back(ref_dec(64, in_instr, in_pc));
        end
    end

    // Present one instruction until accepted; called and returns at posedge+1
    task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input bit rand_bp);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        while (!acc && n < 50) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = b32.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("drive_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid32"}, 64'(b32.out_valid), 64'd0);
        check({tag, "_valid64"}, 64'(b64.out_valid), 64'd0);
        check({tag, "_ready32"}, 64'(b32.in_ready), 64'd1);
        check({tag, "_ready64"}, 64'(b64.in_ready), 64'd1);
    endtask

    logic [6:0]  ops [16] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                              7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B, 7'h0B, 7'h7F};
    logic [31:0] dir [6]  = '{32'h43F0D093, 32'h0200909B, 32'h0010909B, 32'h002080BB,
                              32'h00000010, 32'hFE20AC23};

    initial begin
        logic [31:0] ins;
        logic [63:0] pc;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_illegal", 64'({b32.out_illegal, b64.out_illegal}), 64'd0);
        check("reset_pc", b64.out_pc | 64'(b32.out_pc), 64'd0);
        check("reset_imm", b64.out_imm | 64'(b32.out_imm), 64'd0);
        check("reset_instr", 64'(b64.out_instr | b32.out_instr), 64'd0);
        check("reset_fmt", 64'({b32.out_fmt, b64.out_fmt}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // addi x1,x0,-1
        drive(32'hFFF00093, 64'h100, 0);
        @(negedge clk);
        check("addi_valid", 64'(b32.out_valid), 64'd1);
        check("addi_imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
        check("addi_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt", 64'(b32.out_fmt), 64'(FMT_I));
        check("addi_rd_rs1", 64'({b32.out_rd, b32.out_rs1}), 64'h020);
        @(posedge clk);
        #1;

        // beq x0,x0,-4 then a custom opcode
        drive(32'hFE000EE3, 64'h104, 0);
        @(negedge clk);
        check("beq_imm32", 64'(b32.out_imm), 64'hFFFF_FFFC);
        check("beq_fmt", 64'(b32.out_fmt), 64'(FMT_B));
        @(posedge clk);
        #1;
        drive(32'h0000000B, 64'h108, 0);
        @(negedge clk);
        check("custom_illegal", 64'({b32.out_illegal, b64.out_illegal}), 64'h3);
        check("custom_imm", 64'(b32.out_imm) | b64.out_imm, 64'd0);
        check("custom_fmt", 64'(b32.out_fmt), 64'(FMT_ILL));
        @(posedge clk);
        #1;

        // slli x1,x1,63 and lui x1,0x80000 across both widths
        drive(32'h03F09093, 64'h10C, 0);
        @(negedge clk);
        check("slli64_imm", b64.out_imm, 64'd63);
        check("slli64_fmt", 64'({b64.out_illegal, b64.out_fmt}), 64'(FMT_I));
        check("slli32_illegal", 64'({b32.out_illegal, b32.out_fmt}), 64'h0F);
        @(posedge clk);
        #1;
        drive(32'h800000B7, 64'h110, 0);
        @(negedge clk);
        check("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui32_imm", 64'(b32.out_imm), 64'h8000_0000);
        @(posedge clk);
        #1;

        // Back-pressure: A to output, B to skid, C held by fetch
        out_ready = 1'b0;
        drive(32'h00100113, 64'h200, 0);
        drive(32'h00200193, 64'h204, 0);
        in_valid = 1'b1;
        in_instr = 32'hFE20AC23;
        in_pc    = 64'h208;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_instr", 64'(b32.out_instr), 64'h00100113);
            check("bp_hold_pc", b64.out_pc, 64'h200);
            check("bp_in_ready", 64'({b32.in_ready, b64.in_ready}), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_first", 64'(b32.out_instr), 64'h00100113);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_second", 64'({b32.out_valid, b32.in_ready, b32.out_instr}), {32'h3, 32'h00200193});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_third", 64'({b32.out_valid, b32.out_instr}), {32'h1, 32'hFE20AC23});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_empty", 64'({b32.out_valid, b64.out_valid}), 64'd0);
        @(posedge clk);
        #1;

        // Flush while full, with a third instruction on the input
        out_ready = 1'b0;
        drive(32'h00300213, 64'h300, 0);
        drive(32'h00400293, 64'h304, 0);
        in_valid = 1'b1;
        in_instr = 32'h00500313;
        in_pc    = 64'h308;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("flush");
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_nothing", 64'({b32.out_valid, b64.out_valid}), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(32'h00600393, 64'h400, 0);
        drive(32'h00700413, 64'h404, 0);
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'({b32.out_valid, b64.out_valid}), 64'd0);
        end
        @(posedge clk);
        #1;

        // RV64-only and corner encodings
        pc = 64'h8000_0000_0000_0500;
        foreach (dir[i]) begin
            drive(dir[i], pc, 0);
            pc += 4;
        end

        // Random stream under random back-pressure
        for (int i = 0; i < 40; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 15)];
            drive(ins, pc, 1);
            pc += 4;
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drained32", 64'(q32.size()), 64'd0);
        check("drained64", 64'(q64.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
